// File: rtl/csr_pkg.sv
// Shared CSR addresses, field positions, write masks and reset values
// for the WB-stage CSR register file.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_IE       = 2;
  localparam int PRMD_PIE      = 2;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  localparam logic [31:0] CRMD_RST = 32'h0000_0008;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;

  function automatic logic [31:0] wmerge(input logic [31:0] old,
                                         input logic [31:0] wdata,
                                         input logic [31:0] m);
    return (old & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer with periodic reload and the TI flag
// (set by reaching zero, cleared by TICLR; set wins).
module csr_timer
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] tcfg_m,
  input  logic [31:0] wdata,
  input  logic        ticlr,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        ti
);

  logic        tcfg_wr;
  logic        ti_set;
  logic [31:0] tcfg_nxt;
  logic [31:0] tval_nxt;

  always_comb begin
    tcfg_wr  = |tcfg_m;
    tcfg_nxt = wmerge(tcfg, wdata, tcfg_m);
    ti_set   = 1'b0;
    tval_nxt = tval;
    // A TCFG write restarts the count from the newly written InitVal.
    if (tcfg_wr) begin
      tval_nxt = {tcfg_nxt[31:2], 2'b00};
    end else if (tcfg[TCFG_EN]) begin
      if (tval != 32'h0) begin
        tval_nxt = tval - 32'd1;
        ti_set   = (tval == 32'd1);
      end else if (tcfg[TCFG_PERIODIC]) begin
        tval_nxt = {tcfg[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tcfg <= '0;
      tval <= '0;
      ti   <= 1'b0;
    end else begin
      tcfg <= tcfg_nxt;
      tval <= tval_nxt;
      ti   <= ti_set | (ti & ~ticlr);
    end
  end

endmodule

// File: rtl/csr_file_wb.sv
// WB-stage CSR register file: software/exception updates, combinational
// read port, level interrupt request, redirect target and counters.
module csr_file_wb
  import csr_pkg::*;
#(
  parameter logic [31:0] EENTRY_RST = 32'h0,
  parameter logic [31:0] TID_RST    = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [13:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic [13:0] WB_csr_waddr,
  input  logic [31:0] WB_csr_we,
  input  logic [31:0] WB_csr_wdata,
  input  logic [6:0]  WB_ecode_in,
  input  logic        WB_ecode_we,
  input  logic [31:0] WB_badv_in,
  input  logic        WB_badv_we,
  input  logic [31:0] WB_era_in,
  input  logic        WB_era_we,
  input  logic        WB_store_state,
  input  logic        WB_restore_state,
  input  logic        WB_eentry_en,
  input  logic        WB_era_en,
  input  logic        WB_flush_csr,
  input  logic [31:0] WB_flush_csr_pc,
  input  logic [7:0]  hw_int,
  output logic        interrupt,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  crmd_plv,
  output logic        crmd_ie,
  output logic [63:0] rdcntv,
  output logic [31:0] rdcntid
);

  logic [31:0] crmd, prmd, ecfg, era, badv, eentry, tid;
  logic [31:0] save_r [4];
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [63:0] cnt;
  logic [31:0] tcfg, tval, estat;
  logic        ti;

  logic [31:0] m_crmd, m_prmd, m_ecfg, m_era, m_badv, m_eentry, m_save, m_tid, m_tcfg;
  logic [1:0]  m_estat;
  logic        ticlr_wr;
  logic [31:0] crmd_nxt, prmd_nxt;

  assign m_crmd   = (WB_csr_waddr == CSR_CRMD)   ? (WB_csr_we & CRMD_WMASK)   : '0;
  assign m_prmd   = (WB_csr_waddr == CSR_PRMD)   ? (WB_csr_we & PRMD_WMASK)   : '0;
  assign m_ecfg   = (WB_csr_waddr == CSR_ECFG)   ? (WB_csr_we & ECFG_WMASK)   : '0;
  assign m_estat  = (WB_csr_waddr == CSR_ESTAT)  ? (WB_csr_we[1:0] & ESTAT_WMASK[1:0]) : '0;
  assign m_era    = (WB_csr_waddr == CSR_ERA)    ? (WB_csr_we & FULL_WMASK)   : '0;
  assign m_badv   = (WB_csr_waddr == CSR_BADV)   ? (WB_csr_we & FULL_WMASK)   : '0;
  assign m_eentry = (WB_csr_waddr == CSR_EENTRY) ? (WB_csr_we & EENTRY_WMASK) : '0;
  assign m_tid    = (WB_csr_waddr == CSR_TID)    ? (WB_csr_we & FULL_WMASK)   : '0;
  assign m_tcfg   = (WB_csr_waddr == CSR_TCFG)   ? (WB_csr_we & FULL_WMASK)   : '0;
  assign m_save   = (WB_csr_waddr[13:2] == CSR_SAVE0[13:2]) ? WB_csr_we : '0;
  assign ticlr_wr = (WB_csr_waddr == CSR_TICLR) & WB_csr_we[0] & WB_csr_wdata[0];

  // Exception entry/ERTN override the software write on PLV/IE fields.
  always_comb begin
    crmd_nxt = wmerge(crmd, WB_csr_wdata, m_crmd);
    prmd_nxt = wmerge(prmd, WB_csr_wdata, m_prmd);
    if (WB_store_state) begin
      prmd_nxt[1:0]      = crmd[1:0];
      prmd_nxt[PRMD_PIE] = crmd[CRMD_IE];
      crmd_nxt[1:0]      = 2'b00;
      crmd_nxt[CRMD_IE]  = 1'b0;
    end else if (WB_restore_state) begin
      crmd_nxt[1:0]     = prmd[1:0];
      crmd_nxt[CRMD_IE] = prmd[PRMD_PIE];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      crmd     <= CRMD_RST;
      prmd     <= '0;
      ecfg     <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= EENTRY_RST & EENTRY_WMASK;
      tid      <= TID_RST;
      for (int i = 0; i < 4; i++) save_r[i] <= '0;
      cnt      <= '0;
    end else begin
      crmd  <= crmd_nxt;
      prmd  <= prmd_nxt;
      ecfg  <= wmerge(ecfg, WB_csr_wdata, m_ecfg);
      is_sw <= (is_sw & ~m_estat) | (WB_csr_wdata[1:0] & m_estat);
      is_hw <= hw_int;
      if (WB_ecode_we) begin
        ecode    <= WB_ecode_in[5:0];
        esubcode <= {8'b0, WB_ecode_in[6]};
      end
      era    <= WB_era_we  ? WB_era_in  : wmerge(era, WB_csr_wdata, m_era);
      badv   <= WB_badv_we ? WB_badv_in : wmerge(badv, WB_csr_wdata, m_badv);
      eentry <= wmerge(eentry, WB_csr_wdata, m_eentry);
      tid    <= wmerge(tid, WB_csr_wdata, m_tid);
      for (int i = 0; i < 4; i++)
        if (WB_csr_waddr[1:0] == 2'(i))
          save_r[i] <= wmerge(save_r[i], WB_csr_wdata, m_save);
      cnt <= cnt + 64'd1;
    end
  end

  csr_timer u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .tcfg_m (m_tcfg),
    .wdata  (WB_csr_wdata),
    .ticlr  (ticlr_wr),
    .tcfg   (tcfg),
    .tval   (tval),
    .ti     (ti)
  );

  // IS[12] and IS[10] are never raised here.
  assign estat = {1'b0, esubcode, ecode, 3'b000, 1'b0, ti, 1'b0, is_hw, is_sw};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_CRMD:   rd_data = crmd;
      CSR_PRMD:   rd_data = prmd;
      CSR_ECFG:   rd_data = ecfg;
      CSR_ESTAT:  rd_data = estat;
      CSR_ERA:    rd_data = era;
      CSR_BADV:   rd_data = badv;
      CSR_EENTRY: rd_data = eentry;
      CSR_SAVE0:  rd_data = save_r[0];
      CSR_SAVE1:  rd_data = save_r[1];
      CSR_SAVE2:  rd_data = save_r[2];
      CSR_SAVE3:  rd_data = save_r[3];
      CSR_TID:    rd_data = tid;
      CSR_TCFG:   rd_data = tcfg;
      CSR_TVAL:   rd_data = tval;
      default:    rd_data = '0;
    endcase
  end

  assign interrupt      = crmd[CRMD_IE] & |(estat[12:0] & ecfg[12:0]);
  assign redirect_valid = WB_flush_csr;
  assign redirect_pc    = WB_eentry_en ? eentry : (WB_era_en ? era : WB_flush_csr_pc);
  assign crmd_plv       = crmd[1:0];
  assign crmd_ie        = crmd[CRMD_IE];
  assign rdcntv         = cnt;
  assign rdcntid        = tid;

endmodule

// File: tb/tb_csr_file_wb.sv
// Scoreboard bench for csr_file_wb: directed WB commands push expected
// values; a negedge monitor pops and compares against the DUT outputs.
module tb_csr_file_wb;

  localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004,
                          A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007,
                          A_EENTRY = 14'h00C, A_SAVE0 = 14'h030, A_SAVE2 = 14'h032,
                          A_SAVE3 = 14'h033, A_TID = 14'h040, A_TCFG = 14'h041,
                          A_TVAL = 14'h042, A_TICLR = 14'h044;

  localparam int K_RD = 0, K_INT = 1, K_RVLD = 2, K_CNT = 3, K_ID = 4, K_PLV = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic [13:0] WB_csr_waddr;
  logic [31:0] WB_csr_we, WB_csr_wdata;
  logic [6:0]  WB_ecode_in;
  logic        WB_ecode_we;
  logic [31:0] WB_badv_in, WB_era_in, WB_flush_csr_pc;
  logic        WB_badv_we, WB_era_we, WB_store_state, WB_restore_state;
  logic        WB_eentry_en, WB_era_en, WB_flush_csr;
  logic [7:0]  hw_int;
  logic        interrupt, redirect_valid, crmd_ie;
  logic [31:0] redirect_pc, rdcntid;
  logic [1:0]  crmd_plv;
  logic [63:0] rdcntv;

  csr_file_wb #(.EENTRY_RST(32'h1C00_8000), .TID_RST(32'h0000_00A5)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data),
    .WB_csr_waddr(WB_csr_waddr), .WB_csr_we(WB_csr_we), .WB_csr_wdata(WB_csr_wdata),
    .WB_ecode_in(WB_ecode_in), .WB_ecode_we(WB_ecode_we),
    .WB_badv_in(WB_badv_in), .WB_badv_we(WB_badv_we),
    .WB_era_in(WB_era_in), .WB_era_we(WB_era_we),
    .WB_store_state(WB_store_state), .WB_restore_state(WB_restore_state),
    .WB_eentry_en(WB_eentry_en), .WB_era_en(WB_era_en),
    .WB_flush_csr(WB_flush_csr), .WB_flush_csr_pc(WB_flush_csr_pc),
    .hw_int(hw_int), .interrupt(interrupt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .crmd_plv(crmd_plv), .crmd_ie(crmd_ie), .rdcntv(rdcntv), .rdcntid(rdcntid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } item_t;

  item_t       sc[$];
  logic [31:0] rq[$];
  logic        probe = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [13:0] rst_addr [15] = '{A_CRMD, A_PRMD, A_ECFG, A_ESTAT, A_ERA, A_BADV, A_EENTRY,
                                 A_SAVE0, A_SAVE3, A_TID, A_TCFG, A_TVAL, A_TICLR,
                                 14'h003, 14'h045};
  logic [31:0] rst_exp  [15] = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1C00_8000,
                                 32'h0, 32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: drains the scoreboard on probed cycles, redirect queue on redirect_valid.
  always @(negedge clk) begin
    item_t it;
    logic [31:0] rp;
    if (probe) begin
      while (sc.size() > 0) begin
        it = sc.pop_front();
        case (it.kind)
          K_RD:    cmp(it.name, {32'h0, rd_data}, it.exp);
          K_INT:   cmp(it.name, {63'h0, interrupt}, it.exp);
          K_RVLD:  cmp(it.name, {63'h0, redirect_valid}, it.exp);
          K_CNT:   cmp(it.name, rdcntv, it.exp);
          K_ID:    cmp(it.name, {32'h0, rdcntid}, it.exp);
          default: cmp(it.name, {61'h0, crmd_ie, crmd_plv}, it.exp);
        endcase
      end
    end
    if (redirect_valid) begin
      if (rq.size() == 0) begin
        cmp("redirect_unexpected", {63'h0, redirect_valid}, 64'h0);
      end else begin
        rp = rq.pop_front();
        cmp("redirect_pc", {32'h0, redirect_pc}, {32'h0, rp});
      end
    end
  end

  task automatic push(input int kind, input logic [63:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sc.push_back(it);
    probe = 1'b1;
  endtask

  task automatic expect_rd(input logic [13:0] a, input logic [31:0] e, input string name);
    rd_addr = a;
    push(K_RD, {32'h0, e}, name);
  endtask

  task automatic expect_redir(input logic [31:0] pc);
    rq.push_back(pc);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] we, input logic [31:0] d);
    WB_csr_waddr = a;
    WB_csr_we    = we;
    WB_csr_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe            = 1'b0;
    WB_csr_waddr     = '0;
    WB_csr_we        = '0;
    WB_csr_wdata     = '0;
    WB_ecode_in      = '0;
    WB_ecode_we      = 1'b0;
    WB_badv_in       = '0;
    WB_badv_we       = 1'b0;
    WB_era_in        = '0;
    WB_era_we        = 1'b0;
    WB_store_state   = 1'b0;
    WB_restore_state = 1'b0;
    WB_eentry_en     = 1'b0;
    WB_era_en        = 1'b0;
    WB_flush_csr     = 1'b0;
    WB_flush_csr_pc  = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn    = 1'b0;
    rd_addr = '0;
    hw_int  = '0;
    tick();
    tick();
    tick();
    rstn = 1'b1;

    // Reset state and free-running counter
    for (int i = 0; i < 15; i++) begin
      expect_rd(rst_addr[i], rst_exp[i], "reset_read");
      push(K_CNT, 64'(i), "rdcntv");
      if (i == 0) begin
        push(K_INT, 64'h0, "reset_int");
        push(K_RVLD, 64'h0, "reset_rvld");
        push(K_PLV, 64'h0, "reset_plv_ie");
        push(K_ID, 64'hA5, "reset_rdcntid");
      end
      tick();
    end

    // CRMD write, no read bypass
    wr(A_CRMD, 32'hFFFF_FFFF, 32'h7);
    expect_rd(A_CRMD, 32'h8, "crmd_no_bypass");
    tick();

    // Exception entry with redirect to EENTRY; ERA hw load beats sw write
    expect_rd(A_CRMD, 32'h7, "crmd_written");
    push(K_PLV, 64'h7, "plv_ie_written");
    wr(A_ERA, 32'hFFFF_FFFF, 32'h1234_5678);
    WB_store_state  = 1'b1;
    WB_ecode_we     = 1'b1;
    WB_ecode_in     = 7'h08;
    WB_era_we       = 1'b1;
    WB_era_in       = 32'h1C00_0010;
    WB_badv_we      = 1'b1;
    WB_badv_in      = 32'h3;
    WB_eentry_en    = 1'b1;
    WB_flush_csr    = 1'b1;
    WB_flush_csr_pc = 32'hDEAD_0000;
    expect_redir(32'h1C00_8000);
    tick();
    expect_rd(A_CRMD, 32'h0, "crmd_after_store");
    push(K_PLV, 64'h0, "plv_ie_after_store");
    tick();
    expect_rd(A_PRMD, 32'h7, "prmd_after_store");
    tick();
    expect_rd(A_ESTAT, 32'h0008_0000, "estat_ecode");
    tick();
    expect_rd(A_ERA, 32'h1C00_0010, "era_hw_load");
    tick();
    expect_rd(A_BADV, 32'h3, "badv_hw_load");
    push(K_RVLD, 64'h0, "rvld_idle");
    tick();

    // ERTN
    WB_restore_state = 1'b1;
    WB_era_en        = 1'b1;
    WB_flush_csr     = 1'b1;
    WB_flush_csr_pc  = 32'hDEAD_0000;
    expect_redir(32'h1C00_0010);
    expect_rd(A_CRMD, 32'h0, "crmd_pre_ertn");
    tick();
    expect_rd(A_CRMD, 32'h7, "crmd_after_ertn");
    push(K_PLV, 64'h7, "plv_ie_after_ertn");
    WB_flush_csr    = 1'b1;
    WB_flush_csr_pc = 32'h1C00_0040;
    expect_redir(32'h1C00_0040);
    tick();

    // Timer interrupt, periodic reload, TICLR
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h800);
    tick();
    expect_rd(A_ECFG, 32'h800, "ecfg_lie");
    wr(A_TCFG, 32'hFFFF_FFFF, 32'hF);
    push(K_INT, 64'h0, "int_before_timer");
    tick();
    for (int k = 0; k < 14; k++) begin
      expect_rd(A_TVAL, (k <= 12) ? 32'(12 - k) : 32'd12, "tval_countdown");
      push(K_INT, (k >= 12) ? 64'h1 : 64'h0, "timer_int");
      tick();
    end
    expect_rd(A_ESTAT, 32'h0008_0800, "estat_ti_set");
    wr(A_TICLR, 32'h1, 32'h1);
    tick();
    expect_rd(A_TVAL, 32'd10, "tval_after_clr");
    push(K_INT, 64'h0, "int_after_ticlr");
    tick();
    expect_rd(A_ESTAT, 32'h0008_0000, "estat_ti_clr");
    tick();
    repeat (7) tick();
    expect_rd(A_TVAL, 32'd1, "tval_one");
    wr(A_TICLR, 32'h1, 32'h1);
    tick();
    expect_rd(A_ESTAT, 32'h0008_0800, "ti_set_wins");
    push(K_INT, 64'h1, "int_set_wins");
    wr(A_TICLR, 32'h1, 32'h1);
    tick();
    expect_rd(A_TVAL, 32'd12, "tval_reload");
    push(K_INT, 64'h0, "int_cleared");
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0);
    tick();
    expect_rd(A_TVAL, 32'd0, "tval_stopped");
    tick();

    // Bit-masked CRMD write
    wr(A_CRMD, 32'hFFFF_FFFF, 32'h0);
    tick();
    wr(A_CRMD, 32'h4, 32'hFFFF_FFFF);
    push(K_PLV, 64'h0, "plv_ie_zero");
    tick();
    expect_rd(A_CRMD, 32'h4, "crmd_masked");
    push(K_PLV, 64'h4, "plv_ie_masked");
    tick();

    // hw_int to interrupt latency
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h4);
    tick();
    hw_int = 8'h01;
    push(K_INT, 64'h0, "hwint_same_cycle");
    tick();
    expect_rd(A_ESTAT, 32'h0008_0004, "estat_is_hw");
    push(K_INT, 64'h1, "hwint_int");
    hw_int = 8'h00;
    tick();
    expect_rd(A_ESTAT, 32'h0008_0000, "estat_is_hw_drop");
    push(K_INT, 64'h0, "hwint_int_drop");
    tick();

    // Write masks on the remaining CSRs
    wr(A_SAVE2, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    tick();
    expect_rd(A_SAVE2, 32'hCAFE_F00D, "save2");
    wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    expect_rd(A_ESTAT, 32'h0008_0003, "estat_sw_mask");
    push(K_INT, 64'h0, "int_sw_is_masked");
    wr(A_TVAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    expect_rd(A_TVAL, 32'h0, "tval_readonly");
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    expect_rd(A_ECFG, 32'h1BFF, "ecfg_mask");
    push(K_INT, 64'h1, "int_sw_is");
    wr(A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_903F);
    tick();
    expect_rd(A_EENTRY, 32'h1C00_9000, "eentry_mask");
    wr(A_PRMD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    expect_rd(A_PRMD, 32'h7, "prmd_mask");
    wr(A_TID, 32'hFFFF_FFFF, 32'h1234);
    tick();
    push(K_ID, 64'h1234, "rdcntid_tid");
    tick();

    // Reset during a countdown
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h11);
    tick();
    expect_rd(A_TVAL, 32'd16, "tval_load16");
    tick();
    expect_rd(A_TVAL, 32'd15, "tval_15");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    expect_rd(A_TCFG, 32'h0, "tcfg_after_reset");
    push(K_CNT, 64'h0, "rdcntv_after_reset");
    tick();
    expect_rd(A_TVAL, 32'h0, "tval_after_reset");
    push(K_CNT, 64'h1, "rdcntv_after_reset");
    push(K_INT, 64'h0, "int_after_reset");
    tick();
    expect_rd(A_CRMD, 32'h8, "crmd_after_reset");
    tick();
    tick();

    cmp("scoreboard_drain", 64'(sc.size() + rq.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csr_file_wb.md
# csr_file_wb

- CSR register file at the WB end of the CSR pipeline. It consumes the WB-stage CSR write and exception/ERTN commands and holds CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3/TID/TCFG/TVAL/TICLR.
- It provides a combinational CSR read port to decode/EX.
- It generates the level interrupt request (MEM_interrupt), the exception/ERTN redirect target, and the rdcntv/rdcntid counters.

## Interface
- Parameters
  - EENTRY_RST, 32'h0, EENTRY reset value (bits [5:0] forced 0).
  - TID_RST, 32'h0, TID reset value.
- Ports
  - clk in 1: clock.
  - rstn in 1: reset, synchronous, active-low.
  - rd_addr in 14: CSR read address.
  - rd_data out 32: CSR read data.
  - WB_csr_waddr in 14, WB_csr_we in 32 (bit write mask), WB_csr_wdata in 32: CSR write.
  - WB_ecode_in in 7 ([5:0] Ecode, [6] EsubCode bit0), WB_ecode_we in 1.
  - WB_badv_in in 32, WB_badv_we in 1; WB_era_in in 32, WB_era_we in 1.
  - WB_store_state in 1 (exception entry), WB_restore_state in 1 (ERTN).
  - WB_eentry_en in 1, WB_era_en in 1: redirect target select.
  - WB_flush_csr in 1, WB_flush_csr_pc in 32: flush request, default target.
  - hw_int in 8: hardware interrupt lines, level.
  - interrupt out 1: to MEM_interrupt.
  - redirect_valid out 1, redirect_pc out 32: redirect request and target.
  - crmd_plv out 2, crmd_ie out 1.
  - rdcntv out 64, rdcntid out 32.

## Operation
- Addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Reads: unmapped addresses and TICLR read 0.
- Software write masks:
  - CRMD 0x1FF; PRMD 0x7; ECFG 0x1BFF; ESTAT 0x3 (IS[1:0]).
  - ERA, BADV, SAVE, TID, TCFG all bits; EENTRY 0xFFFF_FFC0.
  - TVAL read-only. TICLR bit0 only, write-1-clears TI.
- Write rule: new = (old & ~m) | (wdata & m), with m = WB_csr_we & mask, applied only when WB_csr_waddr matches.
- Store state (WB_store_state): PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE, CRMD.PLV←0, CRMD.IE←0.
- Restore state (WB_restore_state): CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE.
- Priority on CRMD/PRMD fields: store_state > restore_state > CSR write.
- Exception code: WB_ecode_we writes ESTAT.Ecode[21:16]←ecode[5:0] and EsubCode[30:22]←{8'b0,ecode[6]}.
- ERA/BADV: WB_era_we and WB_badv_we load ERA and BADV; each takes priority over a software write to the same CSR in the same cycle.
- ESTAT.IS[9:2]: sampled from hw_int every cycle. IS[11] = TI. IS[12] = 0.
- interrupt = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational from registers only.
- Redirect:
  - redirect_valid = WB_flush_csr.
  - redirect_pc = WB_eentry_en ? EENTRY : WB_era_en ? ERA : WB_flush_csr_pc.
  - Both combinational; uses the pre-update register values.
- Timer:
  - TCFG write with any we bit set: TVAL←{InitVal,2'b00} next cycle.
  - Else if TCFG.En:
    - TVAL≠0: decrement; reaching 0 (TVAL==1) sets TI.
    - TVAL==0: reload if TCFG.Periodic, else hold 0.
  - TI set and TICLR clear in the same cycle: set wins.
- Counters: rdcntv is a 64-bit free-running +1 per cycle, wrapping. rdcntid = TID.

## Timing
- Reset values:
  - CRMD 0x8 (DA=1); PRMD 0; ECFG 0; ESTAT 0; ERA 0; BADV 0.
  - EENTRY EENTRY_RST; SAVE 0; TID TID_RST; TCFG 0; TVAL 0; TI 0; rdcntv 0.
  - Hence interrupt 0, redirect_valid 0.
- All updates occur on the posedge after the WB inputs.
- No read bypass: a read in the same cycle as a write returns the old value; the new value is visible the next cycle.
- interrupt reflects a change in IE, LIE or IS one cycle after the causing edge.
- hw_int to interrupt latency: 1 cycle.
- Reset mid-countdown clears TCFG/TVAL/TI.

## Structure
- Package csr_pkg: CSR address localparams, field bit positions, write masks, reset values, Ecode constants (INT=0, ADE=8).
- Sub-module csr_timer: TCFG/TVAL/TI countdown, reload and TICLR logic; exports TI and TVAL to the top.

## Test plan
- Reset, then read all CSRs → CRMD=0x8, others 0, EENTRY=EENTRY_RST; rdcntv increments by 1 per cycle.
- CRMD write wdata 0x7, we=0xFFFF_FFFF, then store_state + ecode_we=0x08 + era_we ERA=0x1C00_0010 + badv_we=0x3 → CRMD=0x0, PRMD=0x7, ESTAT[21:16]=0x08, ERA=0x1C00_0010, BADV=0x3.
- Same cycle: eentry_en=1, flush_csr=1, EENTRY=0x1C00_8000 → redirect_pc=0x1C00_8000.
- Follow-up ERTN cycle (restore_state, era_en, flush_csr) → redirect_pc=0x1C00_0010; CRMD PLV=3, IE=1 next cycle.
- ECFG.LIE=0x800, CRMD.IE=1, TCFG=0x0000_000F (InitVal=3, periodic, En) → TVAL 12→0; TI set when TVAL becomes 0, interrupt 1 the following cycle.
- Timer reload behaviour:
  - Periodic: TVAL reloads to 12 the cycle after reaching 0.
  - TICLR write 1 → TI=0, interrupt=0.
  - TICLR write 1 in the same cycle TI is set → TI stays 1.
- Masked write CRMD wdata 0xFFFF_FFFF with we=0x0000_0004 → only IE changes.
- hw_int[0]=1 with LIE bit2 and IE=1 → ESTAT.IS[2]=1 and interrupt=1 after 1 cycle.
